ps2_mouse_decoder: RTL and testbench
====================================

// Module: ps2_mouse_decoder
// PURPOSE
//  PS/2 mouse front end feeding the life-game pointer inputs (pointer_ready/delta_x/delta_y/select).
//  After reset it sends Enable Data Reporting (0xF4) and checks for the 0xFA ack.
//  It then deserialises 3-byte movement packets and converts them into one-cycle pointer updates.
//  Deltas are sign-magnitude, in screen orientation (+y = down).
// PARAMETERS
//  FILTER_LENGTH   4      consecutive equal samples required before a PS/2 line level is accepted
//  INHIBIT_CYCLES  2500   clock-low hold before a host request (100 us at 25 MHz)
//  TIMEOUT_CYCLES  50000  max gap between PS/2 falling edges inside a frame/packet/handshake (2 ms)
// PORTS
//  clock              in   1  system clock, single domain
//  reset              in   1  synchronous, active-high
//  ps2_clock          in   1  raw PS/2 clock line (asynchronous)
//  ps2_data           in   1  raw PS/2 data line (asynchronous)
//  ps2_clock_drive    out  1  1 = pull PS/2 clock low (open-drain enable at top level)
//  ps2_data_drive     out  1  1 = pull PS/2 data low
//  streaming          out  1  high once 0xFA ack received and packets are being decoded
//  pointer_ready      out  1  one-cycle pulse: a new packet has been decoded
//  pointer_delta_x    out  9  [8] = sign (1 = left), [7:0] = magnitude
//  pointer_delta_y    out  9  [8] = sign (1 = up), [7:0] = magnitude
//  pointer_select     out  1  one-cycle pulse, coincident with pointer_ready, on left-button press
// BEHAVIOUR
//  Reset values:
//   - all outputs 0, both lines released
//   - state INHIBIT, packet byte index 0, previous-left-button 0
//  Input conditioning:
//   - 2-flop synchroniser, then a FILTER_LENGTH glitch filter on each line
//   - a bit is sampled on the filtered clock's 1->0 edge
//  Receive frame: start(0), 8 data bits LSB first, odd parity, stop(1).
//   - bad start/parity/stop: drop the byte, packet index -> 0
//   - timeout mid-frame: drop the byte, packet index -> 0
//  State machine:
//   - INHIBIT: clock_drive=1 for INHIBIT_CYCLES.
//       Last cycle sets data_drive=1; next cycle clock_drive=0 -> SEND.
//   - SEND: on each device falling edge, present the next bit.
//       Bits are 0xF4 LSB first, then parity 0. Present a 0 as drive=1, a 1 as drive=0.
//       After the parity edge, release data. On the next edge (stop), -> ACKBIT.
//   - ACKBIT: on the next edge, data must read 0, else -> INHIBIT.
//   - WAITACK: receive one byte.
//       0xFA -> STREAM with streaming=1.
//       Any other byte or a frame error -> INHIBIT.
//   - Timeout in SEND/ACKBIT/WAITACK -> INHIBIT (retry indefinitely).
//   - STREAM: byte 0 is accepted only if bit3=1, otherwise discarded (resync).
//       Bytes 1 and 2 are stored.
//       After byte 2 is accepted, the outputs update on the next cycle with pointer_ready=1 for exactly 1 cycle.
//       Outputs then hold their values until the next packet.
//       A timeout between packet bytes only resets the index to 0; the state stays STREAM.
//  Arithmetic (X raw = {b0[4],b1}, Y raw = {b0[5],b2}, 9-bit two's complement):
//   - x: sign=raw[8], mag=|raw|; mag 256 or overflow b0[6] -> 255.
//   - y: same with b0[7], then sign inverted; zero magnitude always gives sign 0.
//  pointer_select = b0[0] & ~prev_left; prev_left <= b0[0] on every accepted packet.
//  Reset asserted at any point aborts everything in progress and restarts at INHIBIT.
// TESTING
//  - Reset release: ps2_clock low for 2500 cycles, then data low.
//      Model clocks in 0xF4 with parity 0, acks, sends 0xFA -> streaming=1.
//  - Model replies 0xFE instead of 0xFA -> streaming stays 0, new INHIBIT.
//  - Packet 08,05,03 -> one pulse: delta_x=9'h005, delta_y=9'h103 (up 3), select=0.
//  - Packet 39,FB,FE -> delta_x=9'h105, delta_y=9'h002, select=1.
//      Same packet again -> select=0.
//  - Packet 48,10,00 (x overflow) -> delta_x=9'h0FF.
//      Packet 18,00,00 -> delta_x=9'h1FF (-256 clipped).
//  - Corrupt parity on byte 1 -> no pulse.
//      Byte 00 (bit3=0) is discarded; following 08,01,01 -> pulse, x=+1, y=9'h101.
//      Stall 3 ms after byte 0 -> index resets, no spurious pulse.

Source files
------------

// File: rtl/ps2_mouse_decoder.sv
// PS/2 mouse front end: enables data reporting, then turns 3-byte movement
// packets into one-cycle sign-magnitude pointer updates in screen orientation.
module ps2_mouse_decoder #(
    parameter int FILTER_LENGTH  = 4,
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic       ps2_clock_drive,
    output logic       ps2_data_drive,
    output logic       streaming,
    output logic       pointer_ready,
    output logic [8:0] pointer_delta_x,
    output logic [8:0] pointer_delta_y,
    output logic       pointer_select
);

    localparam logic [7:0] ENABLE_CMD = 8'hF4;
    localparam logic       CMD_PARITY = ~^ENABLE_CMD;
    localparam int         IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int         TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {INHIBIT, SEND, ACKBIT, WAITACK, STREAM} state_t;

    state_t                          state;
    logic [1:0]                      raw_lines;
    logic [1:0][1:0]                 sync;
    logic [1:0][FILTER_LENGTH-1:0]   history;
    logic [1:0]                      filtered;
    logic                            clock_prev;
    logic                            fall;
    logic                            line_data;

    logic [TW-1:0]  timer;
    logic           timer_active;
    logic           timeout;

    logic [IW-1:0]  inhibit_count;
    logic [3:0]     send_index;
    logic [3:0]     bit_count;
    logic [9:0]     shift;
    logic [1:0]     byte_index;
    logic [7:4]     header;
    logic           header_left;
    logic [7:0]     b1;
    logic [7:0]     b2;
    logic           packet_pending;
    logic           prev_left;

    logic           frame_done;
    logic           frame_ok;
    logic [7:0]     rx_byte;
    logic [8:0]     x_conv;
    logic [8:0]     y_mag;
    logic [8:0]     y_conv;

    assign raw_lines = {ps2_data, ps2_clock};

    // Line 0 is the PS/2 clock, line 1 the data; a level is accepted only
    // after FILTER_LENGTH identical synchronised samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync       <= '1;
            history    <= '1;
            filtered   <= 2'b11;
            clock_prev <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync[i]    <= {sync[i][0], raw_lines[i]};
                history[i] <= {history[i][FILTER_LENGTH-2:0], sync[i][1]};
                if (&history[i])
                    filtered[i] <= 1'b1;
                else if (~|history[i])
                    filtered[i] <= 1'b0;
            end
            clock_prev <= filtered[0];
        end
    end

    assign fall      = clock_prev & ~filtered[0];
    assign line_data = filtered[1];

    always_comb begin
        timer_active = (state == SEND) || (state == ACKBIT) || (state == WAITACK) ||
                       ((state == STREAM) && ((bit_count != 4'd0) || (byte_index != 2'd0)));
    end

    assign timeout = timer_active && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || !timer_active || fall || timeout)
            timer <= '0;
        else
            timer <= timer + TW'(1);
    end

    // shift[0] holds the start bit, shift[8:1] the data, shift[9] parity;
    // the stop bit is the live data level on the eleventh edge.
    assign frame_done = fall && (bit_count == 4'd10);
    assign rx_byte    = shift[8:1];
    assign frame_ok   = ~shift[0] & (^shift[9:1]) & line_data;

    function automatic logic [8:0] sign_mag(input logic [8:0] raw, input logic overflow);
        logic [8:0] mag;
        mag = raw[8] ? (~raw + 9'd1) : raw;
        if (overflow || mag[8])
            return {raw[8], 8'hFF};
        return {raw[8], mag[7:0]};
    endfunction

    always_comb begin
        x_conv = sign_mag({header[4], b1}, header[6]);
        y_mag  = sign_mag({header[5], b2}, header[7]);
        y_conv = (y_mag[7:0] == 8'd0) ? 9'd0 : {~y_mag[8], y_mag[7:0]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= INHIBIT;
            ps2_clock_drive <= 1'b0;
            ps2_data_drive  <= 1'b0;
            streaming       <= 1'b0;
            pointer_ready   <= 1'b0;
            pointer_delta_x <= '0;
            pointer_delta_y <= '0;
            pointer_select  <= 1'b0;
            inhibit_count   <= '0;
            send_index      <= '0;
            bit_count       <= '0;
            shift           <= '0;
            byte_index      <= '0;
            header          <= '0;
            header_left     <= 1'b0;
            b1              <= '0;
            b2              <= '0;
            packet_pending  <= 1'b0;
            prev_left       <= 1'b0;
        end else begin
            pointer_ready  <= 1'b0;
            pointer_select <= 1'b0;

            if (packet_pending) begin
                packet_pending  <= 1'b0;
                pointer_ready   <= 1'b1;
                pointer_delta_x <= x_conv;
                pointer_delta_y <= y_conv;
                pointer_select  <= header_left & ~prev_left;
                prev_left       <= header_left;
            end

            if (((state == WAITACK) || (state == STREAM)) && fall) begin
                if (bit_count == 4'd10) begin
                    bit_count <= 4'd0;
                end else begin
                    bit_count <= bit_count + 4'd1;
                    shift     <= {line_data, shift[9:1]};
                end
            end

            case (state)
                INHIBIT: begin
                    ps2_clock_drive <= 1'b1;
                    inhibit_count   <= inhibit_count + IW'(1);
                    bit_count       <= 4'd0;
                    byte_index      <= 2'd0;
                    send_index      <= 4'd0;
                    if (inhibit_count == IW'(INHIBIT_CYCLES - 1))
                        ps2_data_drive <= 1'b1;
                    if (inhibit_count == IW'(INHIBIT_CYCLES)) begin
                        ps2_clock_drive <= 1'b0;
                        inhibit_count   <= '0;
                        state           <= SEND;
                    end
                end

                // A 0 bit is sent by pulling the line, a 1 by releasing it.
                SEND: begin
                    if (timeout) begin
                        ps2_data_drive <= 1'b0;
                        state          <= INHIBIT;
                    end else if (fall) begin
                        send_index <= send_index + 4'd1;
                        if (send_index < 4'd8) begin
                            ps2_data_drive <= ~ENABLE_CMD[send_index[2:0]];
                        end else if (send_index == 4'd8) begin
                            ps2_data_drive <= ~CMD_PARITY;
                        end else begin
                            ps2_data_drive <= 1'b0;
                            state          <= ACKBIT;
                        end
                    end
                end

                ACKBIT: begin
                    if (timeout)
                        state <= INHIBIT;
                    else if (fall)
                        state <= line_data ? INHIBIT : WAITACK;
                end

                WAITACK: begin
                    if (timeout) begin
                        state <= INHIBIT;
                    end else if (frame_done) begin
                        if (frame_ok && (rx_byte == 8'hFA)) begin
                            state     <= STREAM;
                            streaming <= 1'b1;
                        end else begin
                            state <= INHIBIT;
                        end
                    end
                end

                // Header bytes must carry bit 3 set; anything else resyncs.
                STREAM: begin
                    if (timeout) begin
                        byte_index <= 2'd0;
                        bit_count  <= 4'd0;
                    end else if (frame_done) begin
                        if (!frame_ok) begin
                            byte_index <= 2'd0;
                        end else begin
                            case (byte_index)
                                2'd0: begin
                                    if (rx_byte[3]) begin
                                        header      <= rx_byte[7:4];
                                        header_left <= rx_byte[0];
                                        byte_index  <= 2'd1;
                                    end
                                end
                                2'd1: begin
                                    b1         <= rx_byte;
                                    byte_index <= 2'd2;
                                end
                                2'd2: begin
                                    b2             <= rx_byte;
                                    byte_index     <= 2'd0;
                                    packet_pending <= 1'b1;
                                end
                                default: byte_index <= 2'd0;
                            endcase
                        end
                    end
                end

                default: state <= INHIBIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// Bench for ps2_mouse_decoder: a behavioural PS/2 mouse on open-drain lines,
// a table of movement packets and a few hand-written timeout/reset sequences.
module tb_ps2_mouse_decoder;

    localparam int FILTER  = 4;
    localparam int INHIBIT = 200;
    localparam int TIMEOUT = 1000;
    localparam int HALF    = 20;
    localparam int NVEC    = 11;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clock;
    logic       ps2_data;
    logic       ps2_clock_drive;
    logic       ps2_data_drive;
    logic       streaming;
    logic       pointer_ready;
    logic [8:0] pointer_delta_x;
    logic [8:0] pointer_delta_y;
    logic       pointer_select;

    int tests_run = 0;
    int tests_failed = 0;

    int   pulse_count = 0;
    int   select_count = 0;
    int   stray_select = 0;
    int   drive_run = 0;
    int   last_run = 0;
    logic data_at_release = 1'b0;

    typedef struct packed {
        logic [31:0] bytes;
        int          nbytes;
        int          corrupt;
        int          exp_pulses;
        logic [8:0]  exp_x;
        logic [8:0]  exp_y;
        int          exp_sel;
    } vec_t;

    vec_t vecs [NVEC];

    assign ps2_clock = dev_clk & ~ps2_clock_drive;
    assign ps2_data  = dev_data & ~ps2_data_drive;

    ps2_mouse_decoder #(
        .FILTER_LENGTH (FILTER),
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ps2_clock      (ps2_clock),
        .ps2_data       (ps2_data),
        .ps2_clock_drive(ps2_clock_drive),
        .ps2_data_drive (ps2_data_drive),
        .streaming      (streaming),
        .pointer_ready  (pointer_ready),
        .pointer_delta_x(pointer_delta_x),
        .pointer_delta_y(pointer_delta_y),
        .pointer_select (pointer_select)
    );

    always #5 clock = ~clock;

    // Tracks pointer pulses and the length of each clock-inhibit interval.
    always @(negedge clock) begin
        if (pointer_ready) pulse_count++;
        if (pointer_select) select_count++;
        if (pointer_select && !pointer_ready) stray_select++;
        if (ps2_clock_drive) begin
            drive_run++;
        end else begin
            if (drive_run != 0) begin
                last_run = drive_run;
                data_at_release = ps2_data_drive;
            end
            drive_run = 0;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] value, input bit bad_parity);
        logic [10:0] frame;
        frame = {1'b1, (~^value) ^ bad_parity, value, 1'b0};
        for (int k = 0; k < 11; k++) begin
            dev_data = frame[k];
            waitCycles(HALF);
            dev_clk = 1'b0;
            waitCycles(HALF);
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
        waitCycles(HALF);
    endtask

    task automatic sendPartial(input int nbits);
        for (int k = 0; k < nbits; k++) begin
            dev_data = (k == 0) ? 1'b0 : 1'b1;
            waitCycles(HALF);
            dev_clk = 1'b0;
            waitCycles(HALF);
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
    endtask

    // Plays the mouse side of a host request, then answers with 'reply'.
    task automatic hostHandshake(input logic [7:0] reply);
        int          budget;
        logic [9:0]  got;
        budget = 0;
        while (ps2_clock_drive !== 1'b1 && budget < 100) begin
            waitCycles(1);
            budget++;
        end
        checkOutput("inhibit begins", ps2_clock_drive, 1);
        budget = 0;
        while (ps2_clock_drive === 1'b1 && budget < INHIBIT + 100) begin
            waitCycles(1);
            budget++;
        end
        checkOutput("inhibit released", ps2_clock_drive, 0);
        waitCycles(1);
        checkOutput("inhibit length", last_run, INHIBIT);
        checkOutput("data low at release", data_at_release, 1);
        waitCycles(HALF);
        checkOutput("request start bit", ps2_data, 0);
        got = '0;
        for (int k = 0; k < 10; k++) begin
            dev_clk = 1'b0;
            waitCycles(HALF);
            got[k] = ps2_data;
            dev_clk = 1'b1;
            waitCycles(HALF);
        end
        checkOutput("host byte", got[7:0], 8'hF4);
        checkOutput("host parity", got[8], 0);
        checkOutput("host stop", got[9], 1);
        dev_data = 1'b0;
        waitCycles(HALF);
        dev_clk = 1'b0;
        waitCycles(HALF);
        dev_clk = 1'b1;
        dev_data = 1'b1;
        waitCycles(HALF);
        sendByte(reply, 1'b0);
    endtask

    task automatic applyStimulus(input vec_t v, output int pulses, output int sels);
        int p0, s0;
        p0 = pulse_count;
        s0 = select_count;
        for (int i = 0; i < v.nbytes; i++) begin
            sendByte(v.bytes[8*i +: 8], i == v.corrupt);
            waitCycles(HALF);
        end
        waitCycles(10);
        pulses = pulse_count - p0;
        sels   = select_count - s0;
    endtask

    initial begin
        int pulses, sels, p0;

        // bytes are listed first-sent in the low byte
        vecs[0]  = '{32'h00030508, 3, -1, 1, 9'h005, 9'h103, 0};
        vecs[1]  = '{32'h00FEFB39, 3, -1, 1, 9'h105, 9'h002, 1};
        vecs[2]  = '{32'h00FEFB39, 3, -1, 1, 9'h105, 9'h002, 0};
        vecs[3]  = '{32'h00001048, 3, -1, 1, 9'h0FF, 9'h000, 0};
        vecs[4]  = '{32'h00000018, 3, -1, 1, 9'h1FF, 9'h000, 0};
        vecs[5]  = '{32'h00800209, 3,  1, 0, 9'h1FF, 9'h000, 0};
        vecs[6]  = '{32'h01010800, 4, -1, 1, 9'h001, 9'h101, 0};
        vecs[7]  = '{32'h00000088, 3, -1, 1, 9'h000, 9'h1FF, 0};
        vecs[8]  = '{32'h000000A8, 3, -1, 1, 9'h000, 9'h0FF, 0};
        vecs[9]  = '{32'h00000008, 3, -1, 1, 9'h000, 9'h000, 0};
        vecs[10] = '{32'h00807F29, 3, -1, 1, 9'h07F, 9'h080, 1};

        waitCycles(5);
        checkOutput("reset clock_drive", ps2_clock_drive, 0);
        checkOutput("reset data_drive", ps2_data_drive, 0);
        checkOutput("reset streaming", streaming, 0);
        checkOutput("reset ready", pointer_ready, 0);
        checkOutput("reset delta_x", pointer_delta_x, 0);
        checkOutput("reset delta_y", pointer_delta_y, 0);
        checkOutput("reset select", pointer_select, 0);
        reset = 1'b0;

        hostHandshake(8'hFE);
        checkOutput("nak streaming", streaming, 0);
        checkOutput("nak retries inhibit", ps2_clock_drive, 1);

        hostHandshake(8'hFA);
        waitCycles(5);
        checkOutput("ack streaming", streaming, 1);

        for (int r = 0; r < NVEC; r++) begin
            applyStimulus(vecs[r], pulses, sels);
            checkOutput($sformatf("row%0d pulses", r), pulses, vecs[r].exp_pulses);
            checkOutput($sformatf("row%0d delta_x", r), pointer_delta_x, vecs[r].exp_x);
            checkOutput($sformatf("row%0d delta_y", r), pointer_delta_y, vecs[r].exp_y);
            checkOutput($sformatf("row%0d select", r), sels, vecs[r].exp_sel);
        end

        p0 = pulse_count;
        sendByte(8'h08, 1'b0);
        waitCycles(TIMEOUT + 500);
        sendByte(8'h01, 1'b0);
        waitCycles(HALF);
        sendByte(8'h01, 1'b0);
        waitCycles(10);
        checkOutput("stall no pulse", pulse_count - p0, 0);
        p0 = pulse_count;
        sendByte(8'h08, 1'b0);
        sendByte(8'h03, 1'b0);
        sendByte(8'h04, 1'b0);
        waitCycles(10);
        checkOutput("after stall pulses", pulse_count - p0, 1);
        checkOutput("after stall delta_x", pointer_delta_x, 9'h003);
        checkOutput("after stall delta_y", pointer_delta_y, 9'h104);

        p0 = pulse_count;
        sendPartial(5);
        waitCycles(TIMEOUT + 500);
        sendByte(8'h08, 1'b0);
        sendByte(8'h02, 1'b0);
        sendByte(8'h00, 1'b0);
        waitCycles(10);
        checkOutput("midframe pulses", pulse_count - p0, 1);
        checkOutput("midframe delta_x", pointer_delta_x, 9'h002);
        checkOutput("midframe delta_y", pointer_delta_y, 9'h000);
        checkOutput("stray select", stray_select, 0);

        reset = 1'b1;
        waitCycles(2);
        checkOutput("rerun streaming", streaming, 0);
        checkOutput("rerun delta_x", pointer_delta_x, 0);
        checkOutput("rerun delta_y", pointer_delta_y, 0);
        checkOutput("rerun clock_drive", ps2_clock_drive, 0);
        reset = 1'b0;
        waitCycles(3);
        checkOutput("rerun inhibit", ps2_clock_drive, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
